teclado_notas: RTL and testbench
================================

# teclado_notas

Keyboard front end for the audio path: debounces 12 note keys and two octave buttons, selects one note by fixed priority, and drives the sample-rate divisor, octave increment and table-length inputs of the codec block (`codec_basico`). Runs on the 50 MHz board clock and feeds `TAXA_AMOSTRAGEM`, `INCREMENTO_AUDIO` and `LARGURA_ENDERECOS_AUDIO` directly.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms): consecutive stable cycles required to accept a level change. Must be ≥1.
- `RELEASE_CYCLES`, default 2_500_000 (50 ms): note hold time after the last key is released. Must be ≥1.
- `TABLE_LEN`, default 9'd256: constant driven on `LARGURA_ENDERECOS_AUDIO`.

Ports:
- `CLOCK_50`  in  1  50 MHz clock; the only clock.
- `RESET`  in  1  synchronous, active-high reset.
- `TECLAS`  in  12  raw note keys, active-high, asynchronous; bit 0 = C4 … bit 11 = B4.
- `OITAVA_MAIS`  in  1  raw octave-up button, active-high, asynchronous.
- `OITAVA_MENOS`  in  1  raw octave-down button, active-high, asynchronous.
- `TAXA_AMOSTRAGEM`  out  17  note divisor; 0 = silence.
- `INCREMENTO_AUDIO`  out  5  table step = 1 << octave.
- `LARGURA_ENDERECOS_AUDIO`  out  9  = `TABLE_LEN`.
- `NOTA_ATIVA`  out  1  high in PLAY and RELEASE.
- `NOTA_IDX`  out  4  index of the sounding note, 0–11.
- `OITAVA`  out  3  current octave, 0–4.

## Operation
- **Input conditioning.** Each of the 14 raw inputs gets a 2-flop synchronizer, then a debouncer.
- **Debouncer.** Holds a stable level and a counter. The counter increments while the synchronized input differs from the stable level and clears when they match. When the counter reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
- **Octave.** Register, range 0–4.
  - A rising edge of debounced `OITAVA_MAIS` increments it, saturating at 4.
  - A rising edge of debounced `OITAVA_MENOS` decrements it, saturating at 0.
  - Both edges in the same cycle: no change.
  - Octave changes take effect in any FSM state.
- **Priority.** The lowest-index debounced key that is set wins.
- **Divisor ROM** (18.432 MHz audio clock divided by note frequency), index 0–11: 70451, 66498, 62766, 59242, 55917, 52779, 49818, 47020, 44382, 41891, 39540, 37321.
- **FSM states**
  - IDLE: no note sounding.
    - Any debounced key set → PLAY, latch the priority index.
  - PLAY:
    - Each cycle, the latched index follows the current priority key (legato: no gap between notes).
    - No key set → RELEASE, load the release counter with `RELEASE_CYCLES`.
  - RELEASE: keeps the last index and decrements the counter.
    - Any key set → PLAY with the new priority index; the counter is abandoned.
    - Counter reaches 1 with no key set → IDLE.
- **Outputs** (all registered):
  - `TAXA_AMOSTRAGEM` = ROM[idx] in PLAY/RELEASE, 0 in IDLE.
  - `NOTA_IDX` holds the last index; it is 0 after reset.

## Timing
- Reset values:
  - Outputs: `TAXA_AMOSTRAGEM`=0, `INCREMENTO_AUDIO`=1, `LARGURA_ENDERECOS_AUDIO`=`TABLE_LEN`, `NOTA_ATIVA`=0, `NOTA_IDX`=0, `OITAVA`=0.
  - Internal: FSM=IDLE; every synchronizer flop, stable level and counter = 0.
- Reset mid-note: silence on the next edge. A key still held after reset is re-accepted only after the full debounce period.
- Key press to output: raw edge at cycle 0 → stable level flips at cycle 2+`DEBOUNCE_CYCLES` → FSM and outputs update on the following edge (total 3+`DEBOUNCE_CYCLES`).
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no change.
- Last key release to silence: 3+`DEBOUNCE_CYCLES`+`RELEASE_CYCLES` cycles. `NOTA_ATIVA` and `TAXA_AMOSTRAGEM` fall on the same edge.
- Octave button to `INCREMENTO_AUDIO`/`OITAVA`: 3+`DEBOUNCE_CYCLES` cycles.
- Outputs change only on the `CLOCK_50` rising edge; there are no combinational paths from input to output.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `RELEASE_CYCLES`=8.
- Reset, hold `TECLAS`=0 for 20 cycles → `TAXA_AMOSTRAGEM`=0, `INCREMENTO_AUDIO`=1, `LARGURA_ENDERECOS_AUDIO`=256, `NOTA_ATIVA`=0.
- Raise bit 9 (A) at cycle 0 → exactly at cycle 7: `TAXA_AMOSTRAGEM`=41891, `NOTA_IDX`=9, `NOTA_ATIVA`=1. A 3-cycle pulse on bit 9 instead → no change.
- Hold bits 4 and 7, then drop bit 4 → `TAXA_AMOSTRAGEM` 55917 then 47020, with no zero cycle between. Drop bit 7 → 47020 held for 8 cycles, then 0 and `NOTA_ATIVA`=0.
- Press `OITAVA_MAIS` 6 times (each held 10 cycles) → `INCREMENTO_AUDIO` 2,4,8,16,16,16 and `OITAVA` saturates at 4. Press both buttons together → no change.
- During RELEASE (counter mid-way), press bit 0 → PLAY, `TAXA_AMOSTRAGEM`=70451 with no silent cycle.
- Assert `RESET` while bit 2 is held and sounding → next edge all outputs at reset values. Bit 2 still held → 62766 reappears 7 cycles after `RESET` drops.

Source files
------------

// File: rtl/teclado_notas.sv
// teclado_notas: debounced 12-key note selector with octave control driving the codec divisor, step and table length.
module teclado_notas #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         RELEASE_CYCLES  = 2_500_000,
  parameter logic [8:0] TABLE_LEN       = 9'd256
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [11:0] TECLAS,
  input  logic        OITAVA_MAIS,
  input  logic        OITAVA_MENOS,
  output logic [16:0] TAXA_AMOSTRAGEM,
  output logic [4:0]  INCREMENTO_AUDIO,
  output logic [8:0]  LARGURA_ENDERECOS_AUDIO,
  output logic        NOTA_ATIVA,
  output logic [3:0]  NOTA_IDX,
  output logic [2:0]  OITAVA
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [16:0] ROM [12] = '{17'd70451, 17'd66498, 17'd62766, 17'd59242, 17'd55917, 17'd52779,
                                       17'd49818, 17'd47020, 17'd44382, 17'd41891, 17'd39540, 17'd37321};
  typedef enum logic [1:0] {IDLE, PLAY, REL} state_t;

  logic [13:0]   raw, s1_q, s2_q, db_q;
  logic [CW-1:0] cnt_q [14];
  logic [1:0]    oct_prev_q;
  logic [2:0]    oit_q, oit_d;
  logic [4:0]    inc_q;
  logic          up, dn, any_key, ativa_q, ativa_d;
  logic [3:0]    prio_idx, idx_q, idx_d;
  logic [RW-1:0] rel_q, rel_d;
  logic [16:0]   taxa_q, taxa_d;
  state_t        state_q, state_d;

  assign raw = {OITAVA_MENOS, OITAVA_MAIS, TECLAS};

  // The flip fires on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      for (int i = 0; i < 14; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int i = 0; i < 14; i++) begin
        if (s2_q[i] == db_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          db_q[i]  <= s2_q[i];
        end else cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

  assign up = db_q[12] & ~oct_prev_q[0];
  assign dn = db_q[13] & ~oct_prev_q[1];

  always_comb oit_d = (up && !dn && oit_q != 3'd4) ? oit_q + 3'd1 :
                      (dn && !up && oit_q != 3'd0) ? oit_q - 3'd1 : oit_q;

  always_comb begin
    prio_idx = 4'd0;
    for (int i = 11; i >= 0; i--) if (db_q[i]) prio_idx = 4'(i);
  end

  assign any_key = |db_q[11:0];

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rel_q      <= '0;
      taxa_q     <= '0;
      ativa_q    <= 1'b0;
      oit_q      <= '0;
      inc_q      <= 5'd1;
      oct_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rel_q      <= rel_d;
      taxa_q     <= taxa_d;
      ativa_q    <= ativa_d;
      oit_q      <= oit_d;
      inc_q      <= 5'd1 << oit_d;
      oct_prev_q <= db_q[13:12];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    if (any_key) begin
      state_d = PLAY;
      idx_d   = prio_idx;
    end else if (state_q == PLAY) begin
      state_d = REL;
      rel_d   = RW'(RELEASE_CYCLES);
    end else if (state_q == REL) begin
      rel_d   = rel_q - RW'(1);
      state_d = (rel_q == RW'(1)) ? IDLE : REL;
    end
  end

  always_comb begin
    taxa_d  = (state_d == IDLE) ? 17'd0 : ROM[idx_d];
    ativa_d = state_d != IDLE;
  end

  assign TAXA_AMOSTRAGEM         = taxa_q;
  assign INCREMENTO_AUDIO        = inc_q;
  assign LARGURA_ENDERECOS_AUDIO = TABLE_LEN;
  assign NOTA_ATIVA              = ativa_q;
  assign NOTA_IDX                = idx_q;
  assign OITAVA                  = oit_q;
endmodule

// File: tb/tb_teclado_notas.sv
// tb_teclado_notas: directed stimulus pushes timed expectations; a monitor pops one on every output change.
module tb_teclado_notas;
  typedef struct packed {
    logic [16:0] taxa;
    logic [4:0]  inc;
    logic [8:0]  larg;
    logic        ativa;
    logic [3:0]  idx;
    logic [2:0]  oit;
  } out_t;
  typedef struct {
    string name;
    int    cyc;
    out_t  v;
  } exp_t;

  logic        clk, rst, mais, menos;
  logic [11:0] teclas;
  logic [16:0] taxa;
  logic [4:0]  inc;
  logic [8:0]  larg;
  logic        ativa;
  logic [3:0]  idx;
  logic [2:0]  oit;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          done = 0;
  exp_t        q[$];
  out_t        last = 'x;

  teclado_notas #(.DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(8)) dut (
    .CLOCK_50(clk), .RESET(rst), .TECLAS(teclas), .OITAVA_MAIS(mais), .OITAVA_MENOS(menos),
    .TAXA_AMOSTRAGEM(taxa), .INCREMENTO_AUDIO(inc), .LARGURA_ENDERECOS_AUDIO(larg),
    .NOTA_ATIVA(ativa), .NOTA_IDX(idx), .OITAVA(oit)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    out_t cur;
    exp_t e;
    cur = '{taxa, inc, larg, ativa, idx, oit};
    if (cur !== last) begin
      last = cur;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d taxa=%0d inc=%0d larg=%0d ativa=%0b idx=%0d oit=%0d",
                 cyc, taxa, inc, larg, ativa, idx, oit);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
          fails++;
          $display("FAIL %s got cyc=%0d taxa=%0d inc=%0d larg=%0d ativa=%0b idx=%0d oit=%0d want cyc=%0d taxa=%0d inc=%0d larg=%0d ativa=%0b idx=%0d oit=%0d",
                   e.name, cyc, taxa, inc, larg, ativa, idx, oit,
                   e.cyc, e.v.taxa, e.v.inc, e.v.larg, e.v.ativa, e.v.idx, e.v.oit);
        end
      end
    end
    if (done) begin
      tests++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL missing_events got %0d pending want 0, next=%s", q.size(), q[0].name);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic push(input string name, input int c, input logic [16:0] t, input logic [3:0] i,
                      input logic a, input logic [4:0] n, input logic [2:0] o);
    exp_t e;
    e.name    = name;
    e.cyc     = c;
    e.v.taxa  = t;
    e.v.inc   = n;
    e.v.larg  = 9'd256;
    e.v.ativa = a;
    e.v.idx   = i;
    e.v.oit   = o;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    logic [4:0] inc_tab [4];
    inc_tab = '{5'd2, 5'd4, 5'd8, 5'd16};
    rst = 1; teclas = '0; mais = 0; menos = 0;
    push("reset_state", -1, 0, 0, 0, 1, 0);
    step(3);
    rst = 0;
    step(20);
    t = cyc; teclas[9] = 1;
    push("press_A", t + 7, 41891, 9, 1, 1, 0);
    step(12);
    t = cyc; teclas[9] = 0;
    push("release_A_silence", t + 15, 0, 9, 0, 1, 0);
    step(20);
    teclas[9] = 1;
    step(3);
    teclas[9] = 0;
    step(20);
    t = cyc; teclas = 12'h090;
    push("press_E_G", t + 7, 55917, 4, 1, 1, 0);
    step(12);
    t = cyc; teclas = 12'h080;
    push("legato_G", t + 7, 47020, 7, 1, 1, 0);
    step(12);
    t = cyc; teclas = '0;
    push("release_G_silence", t + 15, 0, 7, 0, 1, 0);
    step(20);
    for (int k = 0; k < 6; k++) begin
      t = cyc; mais = 1;
      if (k < 4) push("octave_up", t + 7, 0, 7, 0, inc_tab[k], 3'(k + 1));
      step(10);
      mais = 0;
      step(10);
    end
    mais = 1; menos = 1;
    step(10);
    mais = 0; menos = 0;
    step(10);
    t = cyc; menos = 1;
    push("octave_down", t + 7, 0, 7, 0, 8, 3);
    step(10);
    menos = 0;
    step(10);
    t = cyc; teclas = 12'h020;
    push("press_F", t + 7, 52779, 5, 1, 8, 3);
    step(12);
    t = cyc; teclas = '0;
    step(4);
    teclas = 12'h001;
    push("release_retrigger_C", t + 11, 70451, 0, 1, 8, 3);
    step(12);
    t = cyc; teclas = '0;
    push("release_C_silence", t + 15, 0, 0, 0, 8, 3);
    step(20);
    t = cyc; teclas = 12'h004;
    push("press_D", t + 7, 62766, 2, 1, 8, 3);
    step(12);
    t = cyc; rst = 1;
    push("reset_mid_note", t + 1, 0, 0, 0, 1, 0);
    step(2);
    t = cyc; rst = 0;
    push("held_D_after_reset", t + 7, 62766, 2, 1, 1, 0);
    step(12);
    t = cyc; teclas = '0;
    push("release_D_silence", t + 15, 0, 2, 0, 1, 0);
    step(20);
    done = 1;
  end
endmodule
